// File: rtl/conv1_param_sched.sv
// conv1_param_sched: writable bank of NK kernels (KWxKW weights + bias) streamed
// row by row over valid/ready, NWIN windows per kernel per run.
module conv1_param_sched #(
  parameter int DATA_W = 16,
  parameter int KW = 3,
  parameter int NK = 2,
  parameter int NWIN = 26,
  localparam int KI_W = NK > 1 ? $clog2(NK) : 1,
  localparam int WI_W = NWIN > 1 ? $clog2(NWIN) : 1,
  localparam int RI_W = KW > 1 ? $clog2(KW) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [4:0]           cfg_addr,
  input  logic [DATA_W-1:0]    cfg_data,
  output logic                 cfg_err,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic [KW*DATA_W-1:0] filt_row,
  output logic [DATA_W-1:0]    bias,
  output logic [KI_W-1:0]      kern_idx,
  output logic [WI_W-1:0]      win_idx,
  output logic [RI_W-1:0]      row_idx,
  output logic                 win_last
);
  localparam int KSZ = KW * KW + 1;
  localparam int NWORDS = NK * KSZ;
  localparam logic [RI_W-1:0] R_LAST = RI_W'(KW - 1);
  localparam logic [WI_W-1:0] W_LAST = WI_W'(NWIN - 1);
  localparam logic [KI_W-1:0] K_LAST = KI_W'(NK - 1);
  localparam logic [15:0] DFLT [20] = '{
    16'h41, 16'h39, 16'h40, 16'h38, 16'h43, 16'h40, 16'h41, 16'h41, 16'h35, 16'h36,
    16'h37, 16'h39, 16'h42, 16'h40, 16'h43, 16'h42, 16'h39, 16'h41, 16'h38, 16'h36
  };
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state, state_d;
  logic [DATA_W-1:0] bank [NWORDS];
  logic [KI_W-1:0] k_d;
  logic [WI_W-1:0] w_d;
  logic [RI_W-1:0] r_d;
  logic ld, hs, cfg_ok, end_win;

  function automatic logic [KW*DATA_W-1:0] row_of(input logic [KI_W-1:0] k, input logic [RI_W-1:0] r);
    row_of = '0;
    for (int c = 0; c < KW; c++) row_of[c*DATA_W +: DATA_W] = bank[int'(k)*KSZ + int'(r)*KW + c];
  endfunction

  assign hs = state == SEND && row_ready && !abort;
  assign cfg_ok = state == IDLE && int'(cfg_addr) < NWORDS;
  assign end_win = row_idx == R_LAST && win_idx == W_LAST;

  always_comb begin
    state_d = state;
    k_d = kern_idx;
    w_d = win_idx;
    r_d = row_idx;
    ld = 1'b0;
    if (state == IDLE && start) begin
      state_d = SEND;
      k_d = '0;
      w_d = '0;
      r_d = '0;
      ld = 1'b1;
    end else if (state == SEND && abort) state_d = IDLE;
    else if (hs && end_win && kern_idx == K_LAST) state_d = DONE;
    else if (hs) begin
      ld = 1'b1;
      r_d = row_idx == R_LAST ? '0 : row_idx + 1'b1;
      w_d = row_idx != R_LAST ? win_idx : win_idx == W_LAST ? '0 : win_idx + 1'b1;
      k_d = end_win ? kern_idx + 1'b1 : kern_idx;
    end else if (state == DONE) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NWORDS; i++) bank[i] <= i < 20 ? DATA_W'(DFLT[i]) : '0;
    else if (cfg_we && cfg_ok) bank[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kern_idx <= '0;
      win_idx <= '0;
      row_idx <= '0;
      filt_row <= '0;
      bias <= '0;
      row_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      win_last <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_d;
      kern_idx <= k_d;
      win_idx <= w_d;
      row_idx <= r_d;
      if (ld) begin
        filt_row <= row_of(k_d, r_d);
        bias <= bank[int'(k_d)*KSZ + KW*KW];
      end
      row_valid <= state_d == SEND;
      busy <= state_d != IDLE;
      done <= state_d == DONE;
      win_last <= state_d == SEND && r_d == R_LAST;
      cfg_err <= cfg_we && !cfg_ok;
    end
  end
endmodule

// File: tb/tb_conv1_param_sched.sv
// tb_conv1_param_sched: scoreboard bench; a bank model predicts every streamed row.
module tb_conv1_param_sched;
  localparam int KW = 3, NK = 2, NWIN = 26, KSZ = KW * KW + 1, ROWS = NK * NWIN * KW;
  logic clk = 0, rst = 1, cfg_we = 0, start = 0, abort = 0, row_ready = 1;
  logic [4:0] cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic cfg_err, busy, done, row_valid, win_last;
  logic [47:0] filt_row;
  logic [15:0] bias;
  logic [0:0] kern_idx;
  logic [4:0] win_idx;
  logic [1:0] row_idx;

  conv1_param_sched dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .start(start), .abort(abort), .busy(busy), .done(done),
    .row_valid(row_valid), .row_ready(row_ready), .filt_row(filt_row), .bias(bias),
    .kern_idx(kern_idx), .win_idx(win_idx), .row_idx(row_idx), .win_last(win_last)
  );

  always #5 clk = ~clk;

  typedef struct { logic [47:0] f; logic [15:0] b; int k; int w; int r; } exp_t;
  exp_t sb[$];
  exp_t got, held;
  bit stalled = 0;
  int dflt[20] = '{'h41, 'h39, 'h40, 'h38, 'h43, 'h40, 'h41, 'h41, 'h35, 'h36,
                   'h37, 'h39, 'h42, 'h40, 'h43, 'h42, 'h39, 'h41, 'h38, 'h36};
  int model[20];
  int checks = 0, errors = 0, hs_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A run visits every kernel, every window, every row; row r of kernel k is weights r*KW..r*KW+KW-1.
  function automatic void push_run();
    exp_t e;
    for (int k = 0; k < NK; k++)
      for (int w = 0; w < NWIN; w++)
        for (int r = 0; r < KW; r++) begin
          e.f = {16'(model[k*KSZ + r*KW + 2]), 16'(model[k*KSZ + r*KW + 1]), 16'(model[k*KSZ + r*KW])};
          e.b = 16'(model[k*KSZ + KW*KW]);
          e.k = k;
          e.w = w;
          e.r = r;
          sb.push_back(e);
        end
  endfunction

  always @(negedge clk) begin
    if (row_valid && row_ready && !abort && !rst) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got row %0h expected none", filt_row);
      end else begin
        got = sb.pop_front();
        chk("filt_row", filt_row, got.f);
        chk("bias", bias, got.b);
        chk("kern_idx", kern_idx, got.k);
        chk("win_idx", win_idx, got.w);
        chk("row_idx", row_idx, got.r);
        chk("win_last", win_last, got.r == KW - 1);
      end
    end
    if (stalled && row_valid) begin
      chk("hold_data", {filt_row, bias}, {held.f, held.b});
      chk("hold_idx", {kern_idx, win_idx, row_idx}, {1'(held.k), 5'(held.w), 2'(held.r)});
    end
    stalled = row_valid && !row_ready && !rst && !abort;
    held.f = filt_row;
    held.b = bias;
    held.k = int'(kern_idx);
    held.w = int'(win_idx);
    held.r = int'(row_idx);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input int d, input bit exp_err);
    cfg_we = 1;
    cfg_addr = 5'(a);
    cfg_data = 16'(d);
    tick();
    cfg_we = 0;
    chk("cfg_err", cfg_err, exp_err);
    if (!exp_err) model[a] = d;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input bit rnd, input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 3000) begin
      if (rnd) row_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    row_ready = 1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
    end
  endtask

  task automatic finish_run();
    tick();
    chk("idle_busy", busy, 0);
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {busy, done, row_valid, cfg_err, win_last, kern_idx, win_idx, row_idx}, 0);
    chk({name, "_data"}, {filt_row, bias}, 0);
  endtask

  initial begin
    int cyc;
    model = dflt;
    repeat (3) tick();
    chk_zero("reset");
    rst = 0;
    tick();
    chk_zero("post_reset");
    // full-rate run with timing checks
    push_run();
    do_start();
    chk("first_row", filt_row, 48'h0040_0039_0041);
    chk("first_bias", bias, 16'h36);
    chk("start_busy", {busy, row_valid}, 2'b11);
    tick();
    chk("second_row", filt_row, 48'h0040_0043_0038);
    tick();
    chk("third_row", filt_row, 48'h0035_0041_0041);
    repeat (76) tick();
    chk("row78", filt_row, 48'h0042_0039_0037);
    chk("row78_kern", kern_idx, 1);
    wait_done(0, 79, cyc);
    chk("done_cycle", cyc, 157);
    chk("done_state", {busy, row_valid}, 2'b10);
    tick();
    chk("done_pulse", done, 0);
    chk("busy_low", busy, 0);
    chk("sb_drain", sb.size(), 0);
    // randomized backpressure
    hs_cnt = 0;
    push_run();
    do_start();
    wait_done(1, 1, cyc);
    finish_run();
    chk("bp_rows", hs_cnt, ROWS);
    // config writes
    cfg_write(19, 'h55, 0);
    cfg_write(0, 'h1, 0);
    cfg_write(20, 'h1234, 1);
    tick();
    chk("cfg_err_pulse", cfg_err, 0);
    push_run();
    do_start();
    chk("cfg_row0", filt_row, 48'h0040_0039_0001);
    wait_done(0, 1, cyc);
    finish_run();
    // write during busy is rejected
    push_run();
    do_start();
    repeat (9) tick();
    cfg_write(5, 'hbeef, 1);
    wait_done(0, 11, cyc);
    finish_run();
    // abort after 40 handshakes
    hs_cnt = 0;
    push_run();
    do_start();
    repeat (40) tick();
    abort = 1;
    tick();
    abort = 0;
    chk("abort_rv", {row_valid, busy}, 0);
    chk("abort_rows", hs_cnt, 40);
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      chk("abort_nodone", done, 0);
      tick();
    end
    push_run();
    do_start();
    chk("restart_idx", {kern_idx, win_idx, row_idx}, 0);
    chk("restart_row", filt_row, 48'h0040_0039_0001);
    wait_done(0, 1, cyc);
    finish_run();
    // reset mid-run restores defaults; stray start while busy is ignored
    cfg_write(0, 'h77, 0);
    push_run();
    do_start();
    repeat (10) tick();
    start = 1;
    tick();
    start = 0;
    repeat (10) tick();
    rst = 1;
    tick();
    chk_zero("midrun_reset");
    rst = 0;
    sb.delete();
    model = dflt;
    tick();
    push_run();
    do_start();
    chk("rst_default_row", filt_row, 48'h0040_0039_0041);
    chk("rst_default_bias", bias, 16'h36);
    wait_done(0, 1, cyc);
    finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
